dfe_ant_demux: RTL and testbench

DFE_ANT_DEMUX -- requirements
Module: dfe_ant_demux

---
 rtl/dfe_ant_demux.sv | 149 ++++++++++++++
 tb/tb_dfe_ant_demux.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dfe_ant_demux.sv
`default_nettype none
// ============================================================================
// Module   : dfe_ant_demux
// Purpose  : Splits an interleaved two-antenna sample stream into per-antenna
//            outputs, aligned to frame heads, and tracks period alignment
//            through the xant end-of-period marker (HUNT/CHECK/LOCK).
// Revision : 1.0 - initial release
// ============================================================================
module dfe_ant_demux #(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk_491p52,
  input  logic                 rst_491p52,
  input  logic [2:0]           i_bandwidth_nr_mod,
  input  logic                 i_path_fram,
  input  logic                 i_path_xant,
  input  logic [31:0]          i_path_data,
  output logic                 o_ant0_vld,
  output logic [31:0]          o_ant0_data,
  output logic                 o_ant1_vld,
  output logic [31:0]          o_ant1_data,
  output logic                 o_ant_fram,
  output logic                 o_sync_lock,
  output logic                 o_xant_err,
  output logic [ERR_CNT_W-1:0] o_xant_err_cnt
);

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_CHECK = 2'd1,
    ST_LOCK  = 2'd2
  } state_t;

  localparam logic [3:0]           c_LAST_WIDE   = 4'd7;
  localparam logic [3:0]           c_LAST_NARROW = 4'd15;
  localparam logic [ERR_CNT_W-1:0] c_CNT_ONE     = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_wide;
  logic [3:0]            r_slot;
  logic [ERR_CNT_W-1:0]  r_err_cnt;

  logic                  w_wide_in;
  logic [3:0]            w_slot_max;
  logic [3:0]            w_slot_inc;
  logic [3:0]            w_slot;
  logic                  w_aligned;
  logic                  w_last;
  logic                  w_accept;
  logic                  w_err;

  // Slot of the current cycle: frame head forces slot 0, otherwise the held
  // period decides the wrap point. "Aligned" means the counter would have
  // wrapped to 0 on its own this cycle.
  always_comb begin
    w_wide_in  = !((i_bandwidth_nr_mod == 3'd2) || (i_bandwidth_nr_mod == 3'd3));
    w_slot_max = r_wide ? c_LAST_WIDE : c_LAST_NARROW;
    w_slot_inc = (r_slot == w_slot_max) ? 4'd0 : (r_slot + 4'd1);
    w_slot     = i_path_fram ? 4'd0 : w_slot_inc;
    w_aligned  = (w_slot_inc == 4'd0);
    w_last     = (w_slot == w_slot_max);
    w_accept   = (r_state != ST_HUNT) || i_path_fram;
  end

  // Next-state and error decision; a frame head takes priority over any
  // xant mismatch in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    unique case (r_state)
      ST_HUNT: begin
        if (i_path_fram) begin
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK, ST_LOCK: begin
        if (i_path_fram) begin
          if (!w_aligned) begin
            w_err       = 1'b1;
            w_state_nxt = ST_CHECK;
          end else if (w_wide_in != r_wide) begin
            w_state_nxt = ST_CHECK;
          end
        end else if (i_path_xant && w_last) begin
          w_state_nxt = ST_LOCK;
        end else if (i_path_xant != w_last) begin
          w_err       = 1'b1;
          w_state_nxt = ST_HUNT;
        end
      end
      default: w_state_nxt = ST_HUNT;
    endcase
  end

  // State, mode and slot registers; mode is only sampled at a frame head.
  always_ff @(posedge clk_491p52 or negedge rst_491p52) begin
    if (!rst_491p52) begin
      r_state <= ST_HUNT;
      r_wide  <= 1'b1;
      r_slot  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot;
      if (i_path_fram) begin
        r_wide <= w_wide_in;
      end
    end
  end

  // Demultiplexed outputs: slot bit 2 picks the antenna, data holds when idle.
  always_ff @(posedge clk_491p52 or negedge rst_491p52) begin
    if (!rst_491p52) begin
      o_ant0_vld  <= 1'b0;
      o_ant1_vld  <= 1'b0;
      o_ant0_data <= 32'd0;
      o_ant1_data <= 32'd0;
      o_ant_fram  <= 1'b0;
    end else begin
      o_ant0_vld <= w_accept && !w_slot[2];
      o_ant1_vld <= w_accept &&  w_slot[2];
      o_ant_fram <= i_path_fram;
      if (w_accept && !w_slot[2]) begin
        o_ant0_data <= i_path_data;
      end
      if (w_accept && w_slot[2]) begin
        o_ant1_data <= i_path_data;
      end
    end
  end

  // Error pulse and saturating error counter, updated on the same edge.
  always_ff @(posedge clk_491p52 or negedge rst_491p52) begin
    if (!rst_491p52) begin
      o_xant_err <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      o_xant_err <= w_err;
      if (w_err && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + c_CNT_ONE;
      end
    end
  end

  assign o_sync_lock    = (r_state == ST_LOCK);
  assign o_xant_err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dfe_ant_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_dfe_ant_demux
// Purpose  : Self-checking bench for dfe_ant_demux: directed scenarios plus a
//            randomized stream, compared cycle by cycle to a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dfe_ant_demux;

  localparam int CW = 4;
  localparam int M_HUNT = 0, M_CHECK = 1, M_LOCK = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    i_bw = 3'd5;
  logic          i_fram = 1'b0;
  logic          i_xant = 1'b0;
  logic [31:0]   i_data = 32'd0;
  logic          o_ant0_vld, o_ant1_vld, o_ant_fram, o_sync_lock, o_xant_err;
  logic [31:0]   o_ant0_data, o_ant1_data;
  logic [CW-1:0] o_xant_err_cnt;

  int n_asserts = 0;
  int n_fail    = 0;

  // reference model state
  int          m_state, m_pos, m_cnt;
  bit          m_wide;
  bit          e_vld0, e_vld1, e_fram, e_err;
  logic [31:0] e_d0, e_d1;

  dfe_ant_demux #(.ERR_CNT_W(CW)) dut (
    .clk_491p52         (clk),
    .rst_491p52         (rst_n),
    .i_bandwidth_nr_mod (i_bw),
    .i_path_fram        (i_fram),
    .i_path_xant        (i_xant),
    .i_path_data        (i_data),
    .o_ant0_vld         (o_ant0_vld),
    .o_ant0_data        (o_ant0_data),
    .o_ant1_vld         (o_ant1_vld),
    .o_ant1_data        (o_ant1_data),
    .o_ant_fram         (o_ant_fram),
    .o_sync_lock        (o_sync_lock),
    .o_xant_err         (o_xant_err),
    .o_xant_err_cnt     (o_xant_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_HUNT; m_pos = 0; m_cnt = 0; m_wide = 1'b1;
    e_vld0 = 0; e_vld1 = 0; e_fram = 0; e_err = 0; e_d0 = 0; e_d1 = 0;
  endtask

  // One input cycle applied to the model; sets the values expected after the edge.
  task automatic model_step(input bit f, input bit x, input logic [31:0] d, input logic [2:0] code);
    int  per;
    int  pos;
    bit  nw;
    per    = m_wide ? 8 : 16;
    pos    = f ? 0 : (m_pos + 1) % per;
    e_vld0 = 0; e_vld1 = 0; e_err = 0; e_fram = f;
    if (m_state != M_HUNT || f) begin
      if ((pos % 8) < 4) begin e_vld0 = 1; e_d0 = d; end
      else               begin e_vld1 = 1; e_d1 = d; end
    end
    if (f) begin
      nw = !(code == 3'd2 || code == 3'd3);
      if (m_state == M_HUNT) m_state = M_CHECK;
      else if ((m_pos + 1) % per != 0) begin e_err = 1; m_state = M_CHECK; end
      else if (nw != m_wide) m_state = M_CHECK;
      m_wide = nw;
    end else if (m_state != M_HUNT) begin
      if (x && pos == per - 1) m_state = M_LOCK;
      else if (x != (pos == per - 1)) begin e_err = 1; m_state = M_HUNT; end
    end
    if (e_err && m_cnt < (1 << CW) - 1) m_cnt++;
    m_pos = pos;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".vld0"},  o_ant0_vld,      e_vld0);
    check({tag, ".vld1"},  o_ant1_vld,      e_vld1);
    check({tag, ".data0"}, o_ant0_data,     e_d0);
    check({tag, ".data1"}, o_ant1_data,     e_d1);
    check({tag, ".fram"},  o_ant_fram,      e_fram);
    check({tag, ".lock"},  o_sync_lock,     (m_state == M_LOCK));
    check({tag, ".err"},   o_xant_err,      e_err);
    check({tag, ".cnt"},   o_xant_err_cnt,  m_cnt);
  endtask

  task automatic cycle(input bit f, input bit x, input logic [31:0] d,
                       input logic [2:0] code, input string tag);
    i_fram = f; i_xant = x; i_data = d; i_bw = code;
    model_step(f, x, d, code);
    @(posedge clk); #1;
    check_all(tag);
  endtask

  // Asserts reset between edges and verifies outputs clear without a clock.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all(tag);
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  // Runs n periods of a stream with a head at the start and xant on the last slot.
  task automatic run_periods(input int n, input int per, input logic [2:0] code, input string tag);
    for (int k = 0; k < n * per; k++)
      cycle(k == 0, (k % per) == per - 1, k % per, code, tag);
  endtask

  initial begin
    model_reset();
    #3 check_all("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // HUNT ignores data and xant without a frame head
    for (int k = 0; k < 5; k++) cycle(0, k[0], 32'hA0 + k, 3'd5, "hunt_idle");

    // wide mode: data = slot index, lock visible 8 cycles after the head
    run_periods(1, 8, 3'd5, "wide");
    check("wide_lock_t8", o_sync_lock, 1'b1);
    check("wide_ant1_last", o_ant1_data, 32'd7);
    run_periods(1, 8, 3'd5, "wide2");

    // narrow mode from a clean reset; then xant placed at slot 7
    async_reset("rst_narrow");
    run_periods(2, 16, 3'd2, "narrow");
    check("narrow_lock", o_sync_lock, 1'b1);
    for (int k = 0; k < 8; k++) cycle(k == 0, k == 7, 32'h100 + k, 3'd2, "narrow_bad");
    check("narrow_bad_cnt", o_xant_err_cnt, 4'd1);
    check("narrow_bad_unlock", o_sync_lock, 1'b0);

    // locked wide, xant dropped at a period end
    run_periods(2, 8, 3'd6, "relock");
    for (int k = 0; k < 8; k++) cycle(0, 0, 32'h200 + k, 3'd6, "drop_xant");
    check("drop_xant_unlock", o_sync_lock, 1'b0);
    for (int k = 0; k < 4; k++) cycle(0, 0, 32'h300 + k, 3'd6, "drop_idle");

    // locked, frame head injected at slot 3, then relock
    run_periods(2, 8, 3'd4, "lock_b");
    for (int k = 0; k < 3; k++) cycle(0, 0, 32'h400 + k, 3'd4, "pre_inject");
    cycle(1, 0, 32'h4F0, 3'd4, "inject_fram");
    check("inject_err", o_xant_err, 1'b1);
    for (int k = 1; k < 8; k++) cycle(0, k == 7, 32'h500 + k, 3'd4, "realign");
    check("realign_lock", o_sync_lock, 1'b1);

    // counter saturation: 2^CW + 3 forced errors
    for (int k = 0; k < (1 << CW) + 3; k++) begin
      cycle(1, 0, k, 3'd5, "sat_fram");
      cycle(0, 1, k, 3'd5, "sat_err");
    end
    check("sat_cnt", o_xant_err_cnt, 4'hF);

    // randomized stream, mostly well-formed with occasional faults
    begin
      int          g_pos;
      int          g_per;
      logic [2:0]  g_code;
      bit          f, x;
      g_pos = 0; g_per = 8; g_code = 3'd5;
      for (int n = 0; n < 1500; n++) begin
        f = (g_pos == 0 && $urandom_range(0, 2) == 0) || ($urandom_range(0, 120) == 0);
        if (f) begin
          g_pos = 0;
          if ($urandom_range(0, 3) == 0) g_code = 3'($urandom_range(0, 7));
          g_per = (g_code == 3'd2 || g_code == 3'd3) ? 16 : 8;
        end
        x = (g_pos == g_per - 1);
        if ($urandom_range(0, 80) == 0) x = !x;
        cycle(f, x, $urandom, f ? g_code : 3'($urandom_range(0, 7)), "rand");
        g_pos = (g_pos + 1) % g_per;
      end
    end

    // reset mid-period, then no output until the next frame head
    run_periods(1, 8, 3'd5, "pre_rst");
    for (int k = 0; k < 3; k++) cycle(0, 0, 32'h600 + k, 3'd5, "pre_rst_mid");
    async_reset("mid_rst");
    for (int k = 0; k < 6; k++) cycle(0, k == 4, 32'h700 + k, 3'd5, "post_rst");
    check("post_rst_novld", o_ant0_vld | o_ant1_vld, 1'b0);
    run_periods(1, 8, 3'd5, "post_rst_fram");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
